// File: rtl/uart_tx_arb.sv
// uart_tx_arb: shares one UART transmitter between 1-byte command responses
// and a 7-byte telemetry frame (header, pitch, roll, yaw; MSB first).
// Responses win over a pending frame, but a running frame is atomic.
// Optional build macro UART_TX_ARB_RESP_PREEMPT_EN lets a pending response
// slip in between two frame bytes; the frame resumes afterwards unchanged.
module uart_tx_arb #(
    parameter logic [7:0] TLM_HDR = 8'hAA
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        send_resp,
    input  logic [7:0]  resp,
    input  logic        tlm_trig,
    input  logic [15:0] ptch,
    input  logic [15:0] roll,
    input  logic [15:0] yaw,
    input  logic        tx_done,
    output logic        trmt,
    output logic [7:0]  tx_data,
    output logic        tlm_drop,
    output logic        resp_ovfl
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LAUNCH_R = 3'd1,
        WAIT_R   = 3'd2,
        LAUNCH_T = 3'd3,
        WAIT_T   = 3'd4
    } state_t;

    state_t      state_reg, state_next;
    logic [2:0]  idx_reg, idx_next;
    logic [7:0]  resp_buf_reg;
    logic        resp_full_reg;
    logic [47:0] frame_reg;
    logic        tlm_pend_reg;
    logic        frame_active_reg;
    logic [7:0]  tx_data_reg;
    logic        tlm_drop_reg;
    logic        resp_ovfl_reg;

    logic        launch_r;
    logic        launch_t;
    logic        tlm_accept;
    logic [7:0]  frame_byte [0:7];

    // Frame byte table: header followed by the snapshot, most significant first.
    // Entry 7 is never launched; it only keeps the 3-bit index in range.
    assign frame_byte[0] = TLM_HDR;
    assign frame_byte[7] = 8'h00;
    generate
        for (genvar gi = 1; gi < 7; gi++) begin : g_frame_byte
            assign frame_byte[gi] = frame_reg[55-8*gi -: 8];
        end
    endgenerate

    // A byte is launched on the edge that enters a LAUNCH state; the buffer
    // is consumed and tx_data loaded on that same edge.
    assign launch_r   = (state_next == LAUNCH_R);
    assign launch_t   = (state_next == LAUNCH_T);
    assign tlm_accept = tlm_trig && !tlm_pend_reg && !frame_active_reg;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    // Next-state and byte-index selection
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE: begin
                if (resp_full_reg) begin
                    state_next = LAUNCH_R;
                end else if (tlm_pend_reg) begin
                    state_next = LAUNCH_T;
                    idx_next   = 3'd0;
                end
            end
            LAUNCH_R: state_next = WAIT_R;
            WAIT_R: begin
                if (tx_done) begin
`ifdef UART_TX_ARB_RESP_PREEMPT_EN
                    // An inserted response returns straight to the frame.
                    state_next = frame_active_reg ? LAUNCH_T : IDLE;
`else
                    state_next = IDLE;
`endif
                end
            end
            LAUNCH_T: state_next = WAIT_T;
            WAIT_T: begin
                if (tx_done) begin
                    if (idx_reg == 3'd6) begin
                        state_next = IDLE;
                        idx_next   = 3'd0;
                    end else begin
                        idx_next = idx_reg + 3'd1;
`ifdef UART_TX_ARB_RESP_PREEMPT_EN
                        state_next = resp_full_reg ? LAUNCH_R : LAUNCH_T;
`else
                        state_next = LAUNCH_T;
`endif
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = 3'd0;
            end
        endcase
    end

    // Launch strobe is a pure function of state
    always_comb begin
        trmt = (state_reg == LAUNCH_R) || (state_reg == LAUNCH_T);
    end

    // Response buffer and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_buf_reg  <= 8'h00;
            resp_full_reg <= 1'b0;
            resp_ovfl_reg <= 1'b0;
        end else begin
            if (launch_r) begin
                resp_full_reg <= 1'b0;
            end
            if (send_resp) begin
                resp_buf_reg  <= resp;
                resp_full_reg <= 1'b1;
                if (resp_full_reg && !launch_r) begin
                    resp_ovfl_reg <= 1'b1;
                end
            end
        end
    end

    // Telemetry snapshot, pending flag, frame-in-progress flag and drop pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_reg        <= 48'h0;
            tlm_pend_reg     <= 1'b0;
            frame_active_reg <= 1'b0;
            tlm_drop_reg     <= 1'b0;
        end else begin
            tlm_drop_reg <= tlm_trig && !tlm_accept;
            if (tlm_accept) begin
                frame_reg    <= {ptch, roll, yaw};
                tlm_pend_reg <= 1'b1;
            end else if (state_reg == LAUNCH_T && idx_reg == 3'd0) begin
                tlm_pend_reg <= 1'b0;
            end
            if (launch_t && idx_next == 3'd0) begin
                frame_active_reg <= 1'b1;
            end else if (state_reg == WAIT_T && tx_done && idx_reg == 3'd6) begin
                frame_active_reg <= 1'b0;
            end
        end
    end

    // Transmit data register: changes only when a byte is launched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data_reg <= 8'h00;
        end else if (launch_r) begin
            tx_data_reg <= resp_buf_reg;
        end else if (launch_t) begin
            tx_data_reg <= frame_byte[idx_next];
        end
    end

    assign tx_data   = tx_data_reg;
    assign tlm_drop  = tlm_drop_reg;
    assign resp_ovfl = resp_ovfl_reg;

endmodule
